pair_triple_vote_ctrl: RTL

Sequencing controller for the 3-input pair/triple detector, whose output is 1 when at least two of its three inputs are 1. It collects three 1-bit ballots one at a time over a valid/ready input stream. It then evaluates them with the detector function and presents the verdict on a valid/ready output stream. It also keeps saturating tallies of completed rounds and passing rounds, and sits between a serial ballot source and a downstream consumer.

---
 rtl/pair_triple_vote_ctrl.sv | 117 +++++++++++
 1 files changed

// File: rtl/pair_triple_vote_ctrl.sv
// Serial three-ballot pair/triple vote controller.
// Collects ballots, emits a registered verdict, keeps saturating tallies.
module pair_triple_vote_ctrl #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_val,
  output logic             in_rdy,
  input  logic             in_bit,
  output logic             out_val,
  input  logic             out_rdy,
  output logic             out_result,
  input  logic             abort,
  output logic [CNT_W-1:0] round_count,
  output logic [CNT_W-1:0] pass_count
);

  typedef enum logic [1:0] {
    C0  = 2'd0,
    C1  = 2'd1,
    C2  = 2'd2,
    RES = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t state;
  state_t state_nx;

  logic b0;
  logic b1;
  logic b2;

  logic in_xfer;
  logic out_xfer;
  logic maj;

  // Handshake outputs depend only on state and reset.
  always_comb begin
    in_rdy  = reset && (state != RES);
    out_val = (state == RES);
  end

  // Transfers are masked by abort, which wins over both streams.
  always_comb begin
    in_xfer  = in_val && in_rdy && !abort;
    out_xfer = out_val && out_rdy && !abort;
    maj      = (b0 & b1) | (b0 & in_bit) | (b1 & in_bit);
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= C0;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state: advance on each accepted ballot, return on consume or abort.
  always_comb begin
    state_nx = state;
    if (abort) begin
      state_nx = C0;
    end else begin
      unique case (state)
        C0:  if (in_xfer)  state_nx = C1;
        C1:  if (in_xfer)  state_nx = C2;
        C2:  if (in_xfer)  state_nx = RES;
        RES: if (out_xfer) state_nx = C0;
        default: state_nx = C0;
      endcase
    end
  end

  // Ballot capture and registered verdict.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      b0         <= 1'b0;
      b1         <= 1'b0;
      b2         <= 1'b0;
      out_result <= 1'b0;
    end else if (abort) begin
      b0         <= 1'b0;
      b1         <= 1'b0;
      b2         <= 1'b0;
      out_result <= 1'b0;
    end else if (in_xfer) begin
      unique case (state)
        C0: b0 <= in_bit;
        C1: b1 <= in_bit;
        C2: begin
          b2         <= in_bit;
          out_result <= maj;
        end
        default: ;
      endcase
    end
  end

  // Saturating tallies of consumed rounds and passing rounds.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      round_count <= '0;
      pass_count  <= '0;
    end else if (out_xfer) begin
      if (round_count != CNT_MAX) begin
        round_count <= round_count + 1'b1;
      end
      if (out_result && (pass_count != CNT_MAX)) begin
        pass_count <= pass_count + 1'b1;
      end
    end
  end

endmodule
